// File: rtl/shifter_arbiter.sv
// Two-requester round-robin arbiter around one shared barrel shifter.
// Granted request is shifted and registered into a 1-entry rsp buffer.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req_valid[1:0]    : per-requester valid
//   req_ready[1:0]    : per-requester accept (one-hot or zero)
//   req_type0/1 [1:0] : 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   req_num0/1  [7:0] : shift amount
//   req_x0/1    [W-1] : operand
//   rsp_valid/ready   : response handshake
//   rsp_y       [W-1] : shifted result
//   rsp_id            : requester that owns rsp_y

module Shifter #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       i_type,
    input  logic [7:0]       i_num,
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_y
);
    localparam int AW = $clog2(WIDTH);

    logic signed [WIDTH-1:0]   w_sx;
    logic        [AW-1:0]      w_rot;
    logic        [2*WIDTH-1:0] w_dbl;

    assign w_sx  = i_x;
    assign w_rot = i_num[AW-1:0];
    // Rotate by shifting a doubled copy; amount wraps modulo WIDTH.
    assign w_dbl = {i_x, i_x} >> w_rot;

    always_comb begin
        o_y = i_x;
        unique case (i_type)
            2'b00:   o_y = i_x << i_num;
            2'b01:   o_y = i_x >> i_num;
            2'b10:   o_y = w_sx >>> i_num;
            default: o_y = w_dbl[WIDTH-1:0];
        endcase
    end
endmodule

module shifter_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_type0,
    input  logic [1:0]       req_type1,
    input  logic [7:0]       req_num0,
    input  logic [7:0]       req_num1,
    input  logic [WIDTH-1:0] req_x0,
    input  logic [WIDTH-1:0] req_x1,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_id
);
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic [WIDTH-1:0] r_y;
    logic             r_id;

    logic             w_free;
    logic             w_gnt_vld;
    logic             w_gnt_id;
    logic             w_accept;
    logic [1:0]       w_type;
    logic [7:0]       w_num;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_sh_y;

    assign w_free = (r_state == S_EMPTY) || rsp_ready;

    // Under contention the requester not served last wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = 1'b0;
        unique case (req_valid)
            2'b01: begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b0;
            end
            2'b10: begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 1'b1;
            end
            2'b11: begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = ~r_last;
            end
            default: begin
                w_gnt_vld = 1'b0;
                w_gnt_id  = 1'b0;
            end
        endcase
    end

    assign w_accept  = w_free && w_gnt_vld;
    assign req_ready = !w_accept ? 2'b00 :
                       (w_gnt_id ? 2'b10 : 2'b01);

    // With no grant w_gnt_id is 0, so requester 0 feeds the shifter.
    assign w_type = w_gnt_id ? req_type1 : req_type0;
    assign w_num  = w_gnt_id ? req_num1  : req_num0;
    assign w_x    = w_gnt_id ? req_x1    : req_x0;

    Shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .i_type (w_type),
        .i_num  (w_num),
        .i_x    (w_x),
        .o_y    (w_sh_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A drain and a new accept on the same edge keep the buffer FULL.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (w_accept) begin
                    w_state_nxt = S_FULL;
                end else if (rsp_ready) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_y    <= '0;
            r_id   <= 1'b0;
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_y    <= w_sh_y;
            r_id   <= w_gnt_id;
            r_last <= w_gnt_id;
        end
    end

    assign rsp_valid = (r_state == S_FULL);
    assign rsp_y     = r_y;
    assign rsp_id    = r_id;
endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed-vector bench for shifter_arbiter.
// Inputs change and outputs are sampled 1ns after each rising edge.

module tb_shifter_arbiter;
    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_type0;
    logic [1:0]  req_type1;
    logic [7:0]  req_num0;
    logic [7:0]  req_num1;
    logic [31:0] req_x0;
    logic [31:0] req_x1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_y;
    logic        rsp_id;

    int total;
    int bad;

    shifter_arbiter #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_type0 (req_type0),
        .req_type1 (req_type1),
        .req_num0  (req_num0),
        .req_num1  (req_num1),
        .req_x0    (req_x0),
        .req_x1    (req_x1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        do_reset();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b exp=0", rsp_valid);
        end
        total++;
        if (rsp_y !== 32'h0) begin
            bad++;
            $display("FAIL reset_y got=%h exp=00000000", rsp_y);
        end
        total++;
        if (rsp_id !== 1'b0) begin
            bad++;
            $display("FAIL reset_id got=%b exp=0", rsp_id);
        end
        total++;
        if (req_ready !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=00", req_ready);
        end
    endtask

    task automatic test_single();
        req_type0 = 2'b00;
        req_num0  = 8'd1;
        req_x0    = 32'hffffffff;
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL single_ready got=%b exp=01", req_ready);
        end
        step();
        req_valid = 2'b00;
        total++;
        if (rsp_valid !== 1'b1 || rsp_y !== 32'hfffffffe
            || rsp_id !== 1'b0) begin
            bad++;
            $display("FAIL single_rsp got=%b/%h/%b exp=1/fffffffe/0",
                     rsp_valid, rsp_y, rsp_id);
        end
        step();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_contention();
        do_reset();
        req_type0 = 2'b01;
        req_num0  = 8'd31;
        req_x0    = 32'hffffffff;
        req_type1 = 2'b11;
        req_num1  = 8'd1;
        req_x1    = 32'h00000001;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL cont_ready0 got=%b exp=01", req_ready);
        end
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_y !== 32'h00000001
            || rsp_id !== 1'b0) begin
            bad++;
            $display("FAIL cont_rsp0 got=%b/%h/%b exp=1/00000001/0",
                     rsp_valid, rsp_y, rsp_id);
        end
        total++;
        if (req_ready !== 2'b10) begin
            bad++;
            $display("FAIL cont_ready1 got=%b exp=10", req_ready);
        end
        step();
        req_valid = 2'b00;
        total++;
        if (rsp_valid !== 1'b1 || rsp_y !== 32'h80000000
            || rsp_id !== 1'b1) begin
            bad++;
            $display("FAIL cont_rsp1 got=%b/%h/%b exp=1/80000000/1",
                     rsp_valid, rsp_y, rsp_id);
        end
        step();
    endtask

    task automatic test_backpressure();
        req_type0 = 2'b00;
        req_num0  = 8'd1;
        req_x0    = 32'hffffffff;
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        step();
        req_type1 = 2'b01;
        req_num1  = 8'd4;
        req_x1    = 32'hffffffff;
        req_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_y !== 32'hfffffffe
                || rsp_id !== 1'b0 || req_ready !== 2'b00) begin
                bad++;
                $display("FAIL stall_%0d got=%b/%h/%b/%b exp=1/fffffffe/0/00",
                         i, rsp_valid, rsp_y, rsp_id, req_ready);
            end
            step();
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            bad++;
            $display("FAIL bp_release_ready got=%b exp=10", req_ready);
        end
        step();
        req_valid = 2'b00;
        total++;
        if (rsp_valid !== 1'b1 || rsp_y !== 32'h0fffffff
            || rsp_id !== 1'b1) begin
            bad++;
            $display("FAIL bp_reload got=%b/%h/%b exp=1/0fffffff/1",
                     rsp_valid, rsp_y, rsp_id);
        end
        step();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain got=%b exp=0", rsp_valid);
        end
    endtask

    task automatic test_fairness();
        logic [31:0] exp_y;
        do_reset();
        req_type0 = 2'b10;
        req_num0  = 8'd31;
        req_x0    = 32'h7fffffff;
        req_type1 = 2'b10;
        req_num1  = 8'd31;
        req_x1    = 32'h80000000;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_y = (i % 2 == 0) ? 32'h00000000 : 32'hffffffff;
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2)
                || rsp_y !== exp_y) begin
                bad++;
                $display("FAIL fair_%0d got=%b/%b/%h exp=1/%0d/%h",
                         i, rsp_valid, rsp_id, rsp_y, i % 2, exp_y);
            end
        end
        req_valid = 2'b00;
        step();
    endtask

    task automatic test_reset_mid();
        req_type0 = 2'b11;
        req_num0  = 8'd4;
        req_x0    = 32'h0000000f;
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_y !== 32'hf0000000) begin
            bad++;
            $display("FAIL mid_setup got=%b/%h exp=1/f0000000",
                     rsp_valid, rsp_y);
        end
        req_valid = 2'b11;
        do_reset();
        total++;
        if (rsp_valid !== 1'b0 || rsp_y !== 32'h0 || rsp_id !== 1'b0) begin
            bad++;
            $display("FAIL mid_clear got=%b/%h/%b exp=0/00000000/0",
                     rsp_valid, rsp_y, rsp_id);
        end
        req_type0 = 2'b00;
        req_num0  = 8'd0;
        req_x0    = 32'h12345678;
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++;
            $display("FAIL mid_rearb got=%b exp=01", req_ready);
        end
        step();
        req_valid = 2'b00;
        total++;
        if (rsp_id !== 1'b0 || rsp_y !== 32'h12345678) begin
            bad++;
            $display("FAIL mid_first got=%b/%h exp=0/12345678",
                     rsp_id, rsp_y);
        end
        step();
    endtask

    task automatic test_zero_ror();
        rsp_ready = 1'b1;
        req_type0 = 2'b00;
        req_num0  = 8'd0;
        req_x0    = 32'hffffffff;
        req_valid = 2'b01;
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_y !== 32'hffffffff) begin
            bad++;
            $display("FAIL lsl0 got=%b/%h exp=1/ffffffff",
                     rsp_valid, rsp_y);
        end
        req_type0 = 2'b11;
        req_num0  = 8'd31;
        req_x0    = 32'h7fffffff;
        step();
        req_valid = 2'b00;
        total++;
        if (rsp_valid !== 1'b1 || rsp_y !== 32'hfffffffe) begin
            bad++;
            $display("FAIL ror31 got=%b/%h exp=1/fffffffe",
                     rsp_valid, rsp_y);
        end
        step();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        req_valid = 2'b00;
        req_type0 = 2'b00;
        req_type1 = 2'b00;
        req_num0  = 8'd0;
        req_num1  = 8'd0;
        req_x0    = 32'h0;
        req_x1    = 32'h0;
        rsp_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_zero_ror();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
